// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture front end: FSM encoding,
// default geometry and a counter-width helper.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_SKIP    = 2'd1,
        S_ARMED   = 2'd2,
        S_ACTIVE  = 2'd3
    } cap_state_t;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cam_capture_edge_sync.sv
// Input register stage for the camera bus plus vsync/href edge pulses.
// vsync is normalised so that 1 always means "in vertical sync".
module cam_edge_sync #(
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_vs_q,
    output logic       o_href_q,
    output logic [7:0] o_data_q,
    output logic       o_vs_rise,
    output logic       o_vs_fall,
    output logic       o_href_fall
);

    logic       r_vs_q, r_vs_qq;
    logic       r_href_q, r_href_qq;
    logic [7:0] r_data_q;
    logic       w_vs_norm;

    assign w_vs_norm = VS_ACTIVE_HIGH ? i_vsync : ~i_vsync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_q    <= 1'b0;
            r_vs_qq   <= 1'b0;
            r_href_q  <= 1'b0;
            r_href_qq <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_vs_q    <= w_vs_norm;
            r_vs_qq   <= r_vs_q;
            r_href_q  <= i_href;
            r_href_qq <= r_href_q;
            r_data_q  <= i_data;
        end
    end

    assign o_vs_q      = r_vs_q;
    assign o_href_q    = r_href_q;
    assign o_data_q    = r_data_q;
    assign o_vs_rise   = r_vs_q & ~r_vs_qq;
    assign o_vs_fall   = ~r_vs_q & r_vs_qq;
    assign o_href_fall = ~r_href_q & r_href_qq;

endmodule

// File: rtl/cam_capture.sv
// Camera Y8 capture: frame skip after reset/enable, crop to H_RES x V_RES,
// frame-aligned vs_n/de/data output with sticky geometry flags and frame count.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_RES          = DEF_H_RES,
    parameter int V_RES          = DEF_V_RES,
    parameter int SKIP_FRAMES    = 2,
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        ienable,
    input  logic        ivsync,
    input  logic        ihref,
    input  logic [7:0]  idata,
    output logic        ovs_n,
    output logic        ode,
    output logic [7:0]  odata,
    output logic        oframe_start,
    output logic        oline_err,
    output logic        oframe_err,
    output logic [15:0] oframe_cnt
);

    localparam int PXW = cnt_w(H_RES);
    localparam int LNW = cnt_w(V_RES);
    localparam int SKW = cnt_w(SKIP_FRAMES);
    localparam logic [PXW-1:0] PX_MAX = PXW'(H_RES);
    localparam logic [LNW-1:0] LN_MAX = LNW'(V_RES);
    localparam logic [SKW-1:0] SKIP_N = SKW'(SKIP_FRAMES);

    logic       w_vs_q, w_href_q, w_vs_rise, w_vs_fall, w_href_fall;
    logic [7:0] w_data_q;

    cam_edge_sync #(.VS_ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_edge (
        .i_clk      (iclk),
        .i_rst      (irst),
        .i_vsync    (ivsync),
        .i_href     (ihref),
        .i_data     (idata),
        .o_vs_q     (w_vs_q),
        .o_href_q   (w_href_q),
        .o_data_q   (w_data_q),
        .o_vs_rise  (w_vs_rise),
        .o_vs_fall  (w_vs_fall),
        .o_href_fall(w_href_fall)
    );

    cap_state_t     r_state, w_state_nxt;
    logic           r_en_q;
    logic [SKW-1:0] r_skip_cnt;
    logic [PXW-1:0] r_px;
    logic           r_px_ovf;
    logic [LNW-1:0] r_ln;
    logic           r_ovs_n, r_ode, r_frame_start, r_line_err, r_frame_err;
    logic [7:0]     r_odata;
    logic [15:0]    r_frame_cnt;

    logic           w_en_rise, w_active, w_start, w_frame_end, w_skip_inc;
    logic           w_line_end, w_line_bad, w_ode;
    logic [LNW-1:0] w_ln_inc, w_ln_final;

    assign w_en_rise = ienable & ~r_en_q;
    assign w_active  = (r_state == S_ACTIVE);

    // A vsync rise during href closes the line in that same cycle, pixel included.
    assign w_line_end = w_active & (w_href_fall | (w_vs_rise & w_href_q));
    assign w_line_bad = r_px_ovf | (w_href_fall ? (r_px != PX_MAX) : (r_px != PX_MAX - 1'b1));
    assign w_ln_inc   = (r_ln == LN_MAX) ? r_ln : r_ln + 1'b1;
    assign w_ln_final = w_line_end ? w_ln_inc : r_ln;
    assign w_ode      = w_active & w_href_q & (r_px < PX_MAX) & (r_ln < LN_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        w_skip_inc  = 1'b0;
        case (r_state)
            S_WAIT_VS: if (w_vs_q) w_state_nxt = (r_skip_cnt < SKIP_N) ? S_SKIP : S_ARMED;
            S_SKIP: begin
                if (w_vs_rise) begin
                    w_skip_inc = 1'b1;
                    if (r_skip_cnt == SKIP_N - 1'b1) w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_vs_fall && ienable) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = S_ARMED;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT_VS;
        endcase
        // Re-enabling restarts sync and the skip sequence from scratch.
        if (w_en_rise) begin
            w_state_nxt = S_WAIT_VS;
            w_start     = 1'b0;
            w_skip_inc  = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state       <= S_WAIT_VS;
            r_en_q        <= 1'b0;
            r_skip_cnt    <= '0;
            r_px          <= '0;
            r_px_ovf      <= 1'b0;
            r_ln          <= '0;
            r_ovs_n       <= 1'b1;
            r_ode         <= 1'b0;
            r_odata       <= '0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en_q  <= ienable;

            if (w_en_rise)       r_skip_cnt <= '0;
            else if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 1'b1;

            // Overflow bit lets a long line be told apart from an exact one.
            if (w_href_q) begin
                if (r_px == PX_MAX) r_px_ovf <= 1'b1;
                else                r_px     <= r_px + 1'b1;
            end else begin
                r_px     <= '0;
                r_px_ovf <= 1'b0;
            end

            if (w_start)         r_ln <= '0;
            else if (w_line_end) r_ln <= w_ln_inc;

            r_ode         <= w_ode;
            r_odata       <= w_ode ? w_data_q : 8'h00;
            r_ovs_n       <= (r_state == S_ARMED || r_state == S_ACTIVE) ? ~w_vs_q : 1'b1;
            r_frame_start <= w_start;

            if (w_line_end && w_line_bad) r_line_err <= 1'b1;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (w_ln_final < LN_MAX) r_frame_err <= 1'b1;
            end
        end
    end

    assign ovs_n        = r_ovs_n;
    assign ode          = r_ode;
    assign odata        = r_odata;
    assign oframe_start = r_frame_start;
    assign oline_err    = r_line_err;
    assign oframe_err   = r_frame_err;
    assign oframe_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a reduced 8x6 geometry: stimulus pushes
// expected pixels/events, a negedge monitor pops and compares them.
module tb_cam_capture;

    localparam int H    = 8;
    localparam int V    = 6;
    localparam int SKIP = 2;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b1, vs = 1'b0, hr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        ovs_n, ode, ofs, olerr, oferr;
    logic [7:0]  odata;
    logic [15:0] ocnt;

    always #5 clk = ~clk;

    cam_capture #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(SKIP), .VS_ACTIVE_HIGH(1'b1)) dut (
        .iclk(clk), .irst(rst), .ienable(en), .ivsync(vs), .ihref(hr), .idata(din),
        .ovs_n(ovs_n), .ode(ode), .odata(odata), .oframe_start(ofs),
        .oline_err(olerr), .oframe_err(oferr), .oframe_cnt(ocnt)
    );

    typedef struct { logic [7:0] d; int c; } px_t;
    typedef struct { int c; logic [15:0] cnt; bit fe; bit le; } end_t;

    px_t  q_px[$];
    end_t q_end[$];
    int   q_start[$];
    int   q_vs[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // frame-level reference model
    int          m_skip  = SKIP;
    bit          m_open  = 0;
    int          m_lines = 0;
    logic [15:0] m_cnt   = 0;
    bit          m_ferr  = 0, m_lerr = 0;

    int g_drop = -1, g_raise = -1, g_rst_l = -1, g_rst_p = -1;
    bit g_ramp = 0;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        tick();
        vs = v; hr = h; din = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_px.delete(); q_end.delete(); q_start.delete(); q_vs.delete();
        m_open = 0; m_skip = SKIP; m_cnt = 0; m_ferr = 0; m_lerr = 0;
        @(negedge clk);
        chk(ode == 1'b0,   "rst_ode",   ode,   0);
        chk(odata == 8'h0, "rst_odata", odata, 0);
        chk(ovs_n == 1'b1, "rst_vs_n",  ovs_n, 1);
        chk(olerr == 1'b0, "rst_lerr",  olerr, 0);
        chk(oferr == 1'b0, "rst_ferr",  oferr, 0);
        chk(ocnt == 16'd0, "rst_cnt",   ocnt,  0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_vsync();
        drive(1'b1, 1'b0, 8'h00);
        if (m_open) begin
            m_open = 0;
            m_cnt  = m_cnt + 16'd1;
            if (m_lines < V) m_ferr = 1;
            q_end.push_back('{c: cyc + 2, cnt: m_cnt, fe: m_ferr, le: m_lerr});
        end
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int nl, input int np);
        bit armed, cap;
        int hb;
        send_vsync();
        armed = (m_skip == 0);
        cap   = armed && en;
        if (!armed) m_skip--;
        drive(1'b0, 1'b0, 8'h00);
        if (armed) q_vs.push_back(cyc + 2);
        if (cap) begin
            q_start.push_back(cyc + 2);
            m_open  = 1;
            m_lines = 0;
        end
        drive(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            if (l == g_drop) en = 1'b0;
            if (l == g_raise && !en) begin
                en     = 1'b1;
                m_skip = SKIP;
            end
            for (int p = 0; p < np; p++) begin
                logic [7:0] d;
                d = g_ramp ? 8'(p) : 8'($urandom);
                drive(1'b0, 1'b1, d);
                if (cap && l < V && p < H) q_px.push_back('{d: d, c: cyc + 2});
                if (l == g_rst_l && p == g_rst_p) begin
                    do_reset();
                    cap = 0;
                end
            end
            if (cap) begin
                m_lines++;
                if (np != H) m_lerr = 1;
            end
            hb = $urandom_range(4, 2);
            repeat (hb) drive(1'b0, 1'b0, 8'h00);
        end
    endtask

    // monitor
    px_t  mon_px;
    end_t mon_end;
    int   mon_c;
    logic mon_prev_vsn = 1'b1;
    logic [15:0] mon_prev_cnt = 16'd0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ode) begin
                if (q_px.size() == 0) chk(1'b0, "px_unexpected", odata, -1);
                else begin
                    mon_px = q_px.pop_front();
                    chk(odata == mon_px.d, "px_data", odata, mon_px.d);
                    chk(cyc == mon_px.c, "px_cycle", cyc, mon_px.c);
                end
            end else begin
                chk(odata == 8'h00, "odata_idle", odata, 0);
            end
            if (ofs) begin
                if (q_start.size() == 0) chk(1'b0, "start_unexpected", cyc, -1);
                else begin
                    mon_c = q_start.pop_front();
                    chk(cyc == mon_c, "start_cycle", cyc, mon_c);
                end
            end
            if (ovs_n && !mon_prev_vsn) begin
                if (q_vs.size() == 0) chk(1'b0, "vs_n_rise_unexpected", cyc, -1);
                else begin
                    mon_c = q_vs.pop_front();
                    chk(cyc == mon_c, "vs_n_rise_cycle", cyc, mon_c);
                end
            end
            if (ocnt != mon_prev_cnt) begin
                if (q_end.size() == 0) chk(1'b0, "frame_end_unexpected", ocnt, -1);
                else begin
                    mon_end = q_end.pop_front();
                    chk(cyc == mon_end.c, "frame_end_cycle", cyc, mon_end.c);
                    chk(ocnt == mon_end.cnt, "frame_cnt", ocnt, mon_end.cnt);
                    chk(oferr == mon_end.fe, "frame_err", oferr, mon_end.fe);
                    chk(olerr == mon_end.le, "line_err", olerr, mon_end.le);
                end
            end
        end
        mon_prev_vsn = ovs_n;
        mon_prev_cnt = ocnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ovs_n == 1'b1, "init_vs_n", ovs_n, 1);
        chk(ode == 1'b0,   "init_ode",  ode,   0);
        chk(ocnt == 16'd0, "init_cnt",  ocnt,  0);
        chk(ofs == 1'b0,   "init_start", ofs,  0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);

        // two skipped frames, then two captured
        repeat (4) send_frame(V, H);
        // long lines and extra lines: cropped, line error only
        send_frame(V + 2, H + 2);
        // short frame
        send_frame(V - 1, H);
        // enable dropped mid-frame, re-raised in the following frame
        g_drop = 2;  send_frame(V, H); g_drop = -1;
        g_raise = 1; send_frame(V, H); g_raise = -1;
        repeat (3) send_frame(V, H);
        // reset mid-frame
        g_rst_l = 3; g_rst_p = 4; send_frame(V, H); g_rst_l = -1; g_rst_p = -1;
        repeat (3) send_frame(V, H);
        // ramp data
        g_ramp = 1; send_frame(V, H); g_ramp = 0;
        // random geometry
        repeat (6) send_frame($urandom_range(V + 2, V - 1), $urandom_range(H + 2, H - 1));
        send_vsync();
        repeat (6) drive(1'b1, 1'b0, 8'h00);

        chk(q_px.size() == 0,    "px_missing",        q_px.size(),    0);
        chk(q_start.size() == 0, "start_missing",     q_start.size(), 0);
        chk(q_vs.size() == 0,    "vs_n_rise_missing", q_vs.size(),    0);
        chk(q_end.size() == 0,   "frame_end_missing", q_end.size(),   0);
        chk(ocnt == m_cnt,       "final_cnt",  ocnt,  m_cnt);
        chk(olerr == m_lerr,     "final_lerr", olerr, m_lerr);
        chk(oferr == m_ferr,     "final_ferr", oferr, m_ferr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
